itlb_req_queue: RTL and testbench
=================================

# itlb_req_queue

- Age-ordered request buffer between instruction-fetch clients and the ITLB lookup ports.
- Accepts up to NUM_OF_REQ translation requests per cycle and presents the oldest NUM_OF_RES pending requests to the ITLB, so the oldest request is always served first.
- Drives the ready back-pressure signal: 0 whenever fewer than NUM_OF_REQ entries are free.
- Supports a stall input from the ITLB and a pipeline flush.

## Interface
- NUM_OF_REQ, 2, request ports per cycle; 1..DEPTH.
- NUM_OF_RES, 2, ITLB lookup slots per cycle; 1..DEPTH.
- DEPTH, 8, queue entries; power of two, ≥ max(NUM_OF_REQ, NUM_OF_RES).
- VA_W, 39, virtual-address width.
- TAG_W, 4, client tag width; carried unchanged.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_OF_REQ  per-port request valid.
- req_va  in  NUM_OF_REQ×VA_W  per-port virtual address.
- req_tag  in  NUM_OF_REQ×TAG_W  per-port tag.
- ready  out  1  1 when free entries ≥ NUM_OF_REQ.
- stall_req_to_itlb  in  1  ITLB cannot take lookups this cycle.
- flush  in  1  discard all queued and incoming requests.
- lk_valid  out  NUM_OF_RES  slot k holds the k-th oldest entry.
- lk_va  out  NUM_OF_RES×VA_W  slot address.
- lk_tag  out  NUM_OF_RES×TAG_W  slot tag.
- lk_accept  in  NUM_OF_RES  ITLB consumed slot k this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage is a circular buffer:
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
- Enqueue happens only when ready=1 and flush=0:
  - Valid ports are written in ascending port order starting at tail. Port 0 is treated as oldest.
  - Invalid ports are compressed out, with no holes.
  - tail advances by the number of valid ports.
- Requests presented while ready=0 are dropped. The client must hold them and re-present after ready returns.
- Dispatch: slot k shows the entry at head+k when k < count and stall_req_to_itlb=0. Otherwise lk_valid[k]=0.
- Dequeue count d is the number of leading slots with lk_valid[k]&lk_accept[k], stopping at the first unaccepted slot.
  - Accepts after a gap are ignored; that entry stays queued.
  - head advances by d.
- count_next = count + enq − d, applied in the same cycle. Enqueue and dequeue together are legal at any occupancy.
- ready = (DEPTH − count ≥ NUM_OF_REQ), computed from the registered count only. It does not combinationally depend on the same-cycle dequeue.
- flush:
  - Next cycle head=tail=0 and count=0.
  - Same-cycle enqueue is discarded.
  - Same-cycle accepts have no effect on state.
- Reset: head=0, tail=0, count=0. Entry payloads are don't-care.
- Outputs after reset: lk_valid=0, count=0, ready=1.

## Timing
- lk_* and ready are combinational from registered state.
- An entry enqueued in cycle t is first visible on slot 0..NUM_OF_RES−1 in cycle t+1. Minimum queue latency is 1 cycle.
- An accept in cycle t removes the entry at the t→t+1 edge. In cycle t+1 the slots show the next oldest entries.
- stall_req_to_itlb masks lk_valid in the same cycle and freezes head. Enqueue continues during a stall.
- Full: count=DEPTH gives ready=0 and does not overflow. Empty: all lk_valid=0 and no underflow.
- rst asserted mid-operation takes priority over flush, enqueue and dequeue. State is cleared at the next edge.

## Test plan
- Reset, then both ports valid with VA 0x1000/tag 1 and 0x2000/tag 2 in cycle 0.
  - Cycle 1: slot0=0x1000/1, slot1=0x2000/2, count=2.
  - Accept both: count=0 at cycle 2.
- Port1 only valid with 0x3000 → stored at head, appears on slot0 (compression). lk_valid=01.
- Fill with DEPTH=8, NUM_OF_REQ=2, no accepts:
  - ready=1 up to count=6, ready=0 at count 7 and 8.
  - Requests presented while ready=0 are not stored; count stays at its value.
- Gap accept: count=3, lk_accept=10 → nothing dequeued. lk_accept=01 → only the head is removed, count=2.
- Stall plus flush:
  - stall_req_to_itlb=1 → lk_valid=00 while enqueue still raises count.
  - flush with same-cycle valid requests → count=0 next cycle, lk_valid=00.
- Wrap-around: run 20 enqueue/dequeue pairs so head and tail wrap.
  - Every accepted tag matches the insertion order.
  - Issue rst mid-stream → count=0, ready=1 next cycle.

Source files
------------

// File: rtl/itlb_req_queue_if.sv
// Request/lookup bundle between fetch clients, the ITLB request queue and the ITLB.
// The master side is driven by clients and the ITLB. The slave side is the queue itself.
interface itlb_req_queue_if #(
  parameter int NUM_OF_REQ = 2,
  parameter int NUM_OF_RES = 2,
  parameter int DEPTH      = 8,
  parameter int VA_W       = 39,
  parameter int TAG_W      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_OF_REQ-1:0]             req_valid;
  logic [NUM_OF_REQ-1:0][VA_W-1:0]   req_va;
  logic [NUM_OF_REQ-1:0][TAG_W-1:0]  req_tag;
  logic                              ready;
  logic                              stall_req_to_itlb;
  logic                              flush;
  logic [NUM_OF_RES-1:0]             lk_valid;
  logic [NUM_OF_RES-1:0][VA_W-1:0]   lk_va;
  logic [NUM_OF_RES-1:0][TAG_W-1:0]  lk_tag;
  logic [NUM_OF_RES-1:0]             lk_accept;
  logic [CNT_W-1:0]                  count;

  modport master (
    output req_valid, req_va, req_tag, stall_req_to_itlb, flush, lk_accept,
    input  ready, lk_valid, lk_va, lk_tag, count
  );

  modport slave (
    input  req_valid, req_va, req_tag, stall_req_to_itlb, flush, lk_accept,
    output ready, lk_valid, lk_va, lk_tag, count
  );
endinterface

// File: rtl/itlb_req_queue.sv
// Age-ordered circular request buffer in front of the ITLB lookup ports.
// Compresses valid requests into the tail and presents the oldest entries in order.
module itlb_req_queue #(
  parameter int NUM_OF_REQ = 2,
  parameter int NUM_OF_RES = 2,
  parameter int DEPTH      = 8,
  parameter int VA_W       = 39,
  parameter int TAG_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  itlb_req_queue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [VA_W-1:0]  va_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic                             enq_en;
  logic [CNT_W-1:0]                 enq_cnt;
  logic [CNT_W-1:0]                 deq_cnt;
  logic [NUM_OF_REQ-1:0][PTR_W-1:0] wr_idx;
  logic                             deq_run;

  // Back-pressure looks only at registered occupancy, never at this cycle's dequeue.
  assign bus.ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NUM_OF_REQ);
  assign bus.count = count_q;
  assign enq_en    = bus.ready && !bus.flush;

  // Each valid port lands at tail plus the number of valid ports below it.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    enq_cnt = '0;
    wr_idx  = '0;
    for (int p = 0; p < NUM_OF_REQ; p++) begin
      wr_idx[p] = tail_q + PTR_W'(enq_cnt);
      if (bus.req_valid[p]) enq_cnt = enq_cnt + CNT_W'(1);
    end
  end

  // Slot k shows head+k. Dequeue counts only the unbroken run of accepted leading slots.
  always_comb begin
    bus.lk_valid = '0;
    bus.lk_va    = '0;
    bus.lk_tag   = '0;
    deq_cnt      = '0;
    deq_run      = 1'b1;
    for (int k = 0; k < NUM_OF_RES; k++) begin
      bus.lk_va[k]    = va_mem[head_q + PTR_W'(k)];
      bus.lk_tag[k]   = tag_mem[head_q + PTR_W'(k)];
      bus.lk_valid[k] = !bus.stall_req_to_itlb && (CNT_W'(k) < count_q);
      if (deq_run && bus.lk_valid[k] && bus.lk_accept[k]) deq_cnt = deq_cnt + CNT_W'(1);
      else                                                 deq_run = 1'b0;
    end
  end

  // NOTE: payload storage has no reset; occupancy is tracked by count, so stale data is never shown.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      for (int p = 0; p < NUM_OF_REQ; p++) begin
        if (bus.req_valid[p]) begin
          va_mem[wr_idx[p]]  <= bus.req_va[p];
          tag_mem[wr_idx[p]] <= bus.req_tag[p];
        end
      end
    end
  end

  // Reset outranks flush, and flush outranks any same-cycle enqueue or dequeue.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    if (rst || bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(deq_cnt);
      if (enq_en) tail_q <= tail_q + PTR_W'(enq_cnt);
      count_q <= count_q + (enq_en ? enq_cnt : CNT_W'(0)) - deq_cnt;
    end
  end
endmodule

// File: tb/tb_itlb_req_queue.sv
// Scoreboard bench for itlb_req_queue: a queue model tracks accepted requests in age order.
module tb_itlb_req_queue;
  localparam int NUM_OF_REQ = 2;
  localparam int NUM_OF_RES = 2;
  localparam int DEPTH      = 8;
  localparam int VA_W       = 39;
  localparam int TAG_W      = 4;

  typedef struct packed {
    logic [VA_W-1:0]  va;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itlb_req_queue_if #(.NUM_OF_REQ(NUM_OF_REQ), .NUM_OF_RES(NUM_OF_RES), .DEPTH(DEPTH),
                      .VA_W(VA_W), .TAG_W(TAG_W)) bus ();

  itlb_req_queue #(.NUM_OF_REQ(NUM_OF_REQ), .NUM_OF_RES(NUM_OF_RES), .DEPTH(DEPTH),
                   .VA_W(VA_W), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  entry_t          sb[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [TAG_W-1:0] tag_seq = '0;

  task automatic idle();
    bus.req_valid         = '0;
    bus.req_va            = '0;
    bus.req_tag           = '0;
    bus.stall_req_to_itlb = 1'b0;
    bus.flush             = 1'b0;
    bus.lk_accept         = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [NUM_OF_REQ-1:0] v,
                         input logic [VA_W-1:0] va0, input logic [TAG_W-1:0] tg0,
                         input logic [VA_W-1:0] va1, input logic [TAG_W-1:0] tg1);
    bus.req_valid  = v;
    bus.req_va[0]  = va0;
    bus.req_tag[0] = tg0;
    bus.req_va[1]  = va1;
    bus.req_tag[1] = tg1;
  endtask

  // Advance one clock while updating the reference queue from the driven inputs.
  task automatic cycle();
    int d;
    bit rdy;
    rdy = (DEPTH - sb.size()) >= NUM_OF_REQ;
    d = 0;
    if (!bus.stall_req_to_itlb)
      for (int k = 0; k < NUM_OF_RES; k++)
        if (k < sb.size() && bus.lk_accept[k] && d == k) d++;
    tick();
    if (bus.flush) sb.delete();
    else begin
      repeat (d) void'(sb.pop_front());
      if (rdy)
        for (int p = 0; p < NUM_OF_REQ; p++)
          if (bus.req_valid[p]) sb.push_back('{va: bus.req_va[p], tag: bus.req_tag[p]});
    end
  endtask

  task automatic drain();
    for (int g = 0; g < 2 * DEPTH && sb.size() > 0; g++) begin
      idle();
      bus.lk_accept = '1;
      cycle();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
    n_cmp++; if (bus.count !== 4'd0)    begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.lk_valid !== 2'b00) begin n_err++; $display("FAIL reset_lk_valid: got %b want 00", bus.lk_valid); end
    n_cmp++; if (bus.ready !== 1'b1)    begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_basic();
    idle();
    set_req(2'b11, 39'h1000, 4'd1, 39'h2000, 4'd2);
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.lk_valid !== 2'b11) begin n_err++; $display("FAIL basic_lk_valid: got %b want 11", bus.lk_valid); end
    n_cmp++; if (bus.lk_va[0] !== 39'h1000 || bus.lk_tag[0] !== 4'd1)
      begin n_err++; $display("FAIL basic_slot0: got %0h/%0d want 1000/1", bus.lk_va[0], bus.lk_tag[0]); end
    n_cmp++; if (bus.lk_va[1] !== 39'h2000 || bus.lk_tag[1] !== 4'd2)
      begin n_err++; $display("FAIL basic_slot1: got %0h/%0d want 2000/2", bus.lk_va[1], bus.lk_tag[1]); end
    n_cmp++; if (bus.count !== 4'd2) begin n_err++; $display("FAIL basic_count: got %0d want 2", bus.count); end
    bus.lk_accept = 2'b11;
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL basic_drain_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.lk_valid !== 2'b00) begin n_err++; $display("FAIL basic_drain_valid: got %b want 00", bus.lk_valid); end
  endtask

  task automatic test_compress();
    idle();
    set_req(2'b10, 39'h0, 4'd0, 39'h3000, 4'd3);
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.lk_valid !== 2'b01) begin n_err++; $display("FAIL compress_lk_valid: got %b want 01", bus.lk_valid); end
    n_cmp++; if (bus.lk_va[0] !== 39'h3000 || bus.lk_tag[0] !== 4'd3)
      begin n_err++; $display("FAIL compress_slot0: got %0h/%0d want 3000/3", bus.lk_va[0], bus.lk_tag[0]); end
    n_cmp++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL compress_count: got %0d want 1", bus.count); end
    drain();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      idle();
      set_req(2'b11, 39'h4000 + 39'(2 * i), tag_seq, 39'h4001 + 39'(2 * i), tag_seq + 4'd1);
      tag_seq = tag_seq + 4'd2;
      #1;
      n_cmp++; if (bus.ready !== 1'b1 || bus.count !== 4'(2 * i))
        begin n_err++; $display("FAIL fill_ready_%0d: got ready=%b count=%0d want 1/%0d", i, bus.ready, bus.count, 2 * i); end
      cycle();
    end
    idle();
    #1;
    n_cmp++; if (bus.ready !== 1'b0 || bus.count !== 4'd8)
      begin n_err++; $display("FAIL full_state: got ready=%b count=%0d want 0/8", bus.ready, bus.count); end
    set_req(2'b11, 39'h5000, 4'hE, 39'h5001, 4'hF);
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_drop: got %0d want 8", bus.count); end
    n_cmp++; if (bus.lk_tag[0] !== sb[0].tag) begin n_err++; $display("FAIL full_head_tag: got %0d want %0d", bus.lk_tag[0], sb[0].tag); end
    bus.lk_accept = 2'b01;
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.ready !== 1'b0 || bus.count !== 4'd7)
      begin n_err++; $display("FAIL count7_state: got ready=%b count=%0d want 0/7", bus.ready, bus.count); end
    set_req(2'b01, 39'h6000, 4'hD, 39'h0, 4'h0);
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd7) begin n_err++; $display("FAIL count7_drop: got %0d want 7", bus.count); end
    for (int g = 0; g < 2 * DEPTH && sb.size() > 0; g++) begin
      idle();
      #1;
      n_cmp++; if (bus.lk_va[0] !== sb[0].va || bus.lk_tag[0] !== sb[0].tag)
        begin n_err++; $display("FAIL fill_order: got %0h/%0d want %0h/%0d", bus.lk_va[0], bus.lk_tag[0], sb[0].va, sb[0].tag); end
      bus.lk_accept = 2'b11;
      cycle();
    end
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL fill_empty: got %0d want 0", bus.count); end
  endtask

  task automatic test_gap_accept();
    logic [TAG_W-1:0] next_tag;
    idle();
    set_req(2'b11, 39'h7000, 4'd7, 39'h7001, 4'd8);
    cycle();
    idle();
    set_req(2'b01, 39'h7002, 4'd9, 39'h0, 4'd0);
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL gap_setup: got %0d want 3", bus.count); end
    bus.lk_accept = 2'b10;
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd3 || bus.lk_tag[0] !== 4'd7)
      begin n_err++; $display("FAIL gap_ignored: got count=%0d tag=%0d want 3/7", bus.count, bus.lk_tag[0]); end
    bus.lk_accept = 2'b01;
    cycle();
    next_tag = sb[0].tag;
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd2 || bus.lk_tag[0] !== next_tag)
      begin n_err++; $display("FAIL gap_head_only: got count=%0d tag=%0d want 2/%0d", bus.count, bus.lk_tag[0], next_tag); end
    drain();
  endtask

  task automatic test_stall_flush();
    idle();
    set_req(2'b11, 39'h8000, 4'd1, 39'h8001, 4'd2);
    cycle();
    idle();
    bus.stall_req_to_itlb = 1'b1;
    bus.lk_accept = 2'b11;
    set_req(2'b11, 39'h8002, 4'd3, 39'h8003, 4'd4);
    #1;
    n_cmp++; if (bus.lk_valid !== 2'b00) begin n_err++; $display("FAIL stall_mask: got %b want 00", bus.lk_valid); end
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd4) begin n_err++; $display("FAIL stall_enqueue: got %0d want 4", bus.count); end
    n_cmp++; if (bus.lk_valid !== 2'b11 || bus.lk_tag[0] !== sb[0].tag)
      begin n_err++; $display("FAIL stall_head_frozen: got %b/%0d want 11/%0d", bus.lk_valid, bus.lk_tag[0], sb[0].tag); end
    bus.flush = 1'b1;
    bus.lk_accept = 2'b11;
    set_req(2'b11, 39'h9000, 4'd5, 39'h9001, 4'd6);
    cycle();
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd0 || bus.lk_valid !== 2'b00 || bus.ready !== 1'b1)
      begin n_err++; $display("FAIL flush_clear: got count=%0d lk_valid=%b ready=%b want 0/00/1", bus.count, bus.lk_valid, bus.ready); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      idle();
      set_req(2'b01, 39'h10000 + 39'(i), 4'(i), 39'h0, 4'd0);
      #1;
      if (sb.size() > 0) begin
        n_cmp++; if (bus.lk_valid[0] !== 1'b1 || bus.lk_va[0] !== sb[0].va || bus.lk_tag[0] !== sb[0].tag)
          begin n_err++; $display("FAIL wrap_order_%0d: got %b %0h/%0d want 1 %0h/%0d", i, bus.lk_valid[0], bus.lk_va[0], bus.lk_tag[0], sb[0].va, sb[0].tag); end
        bus.lk_accept = 2'b01;
      end
      cycle();
    end
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", bus.count); end
  endtask

  task automatic test_reset_mid();
    idle();
    rst = 1'b1;
    set_req(2'b11, 39'hA000, 4'd1, 39'hA001, 4'd2);
    bus.lk_accept = 2'b01;
    tick();
    rst = 1'b0;
    sb.delete();
    idle();
    #1;
    n_cmp++; if (bus.count !== 4'd0 || bus.ready !== 1'b1 || bus.lk_valid !== 2'b00)
      begin n_err++; $display("FAIL reset_mid: got count=%0d ready=%b lk_valid=%b want 0/1/00", bus.count, bus.ready, bus.lk_valid); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_compress();
    test_fill();
    test_gap_accept();
    test_stall_flush();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
